ni_inject_fifo: RTL and testbench

//  Network-interface injection stage that sits directly downstream of a per-node dataout_buf traffic source.

---
 rtl/noc_pkg.sv | 16 +
 rtl/ni_inject_fifo_if.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 52 +++++
 rtl/ni_inject_fifo.sv | 77 +++++++
 tb/tb_ni_inject_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: widths, field offsets and the flit layout.
package noc_pkg;
  localparam int FLIT_W           = 20;
  localparam int PAYLOAD_W        = 16;
  localparam int CLUSTER_W        = 2;
  localparam int LOCAL_W          = 2;
  localparam int DEST_LOCAL_LSB   = 0;
  localparam int DEST_CLUSTER_LSB = 2;
  localparam int PAYLOAD_LSB      = 4;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [CLUSTER_W-1:0] dest_cluster;
    logic [LOCAL_W-1:0]   dest_local;
  } flit_t;
endpackage

// File: rtl/ni_inject_fifo_if.sv
// Flit handshake bundle between the traffic source, the injection FIFO and the router port.
interface ni_inject_fifo_if;
  import noc_pkg::*;

  logic [FLIT_W-1:0] in_data;
  logic              in_valid;
  logic [FLIT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_local;

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_is_local
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_is_local
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo_fwft #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             rd_ok, wr_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is legal only when the head slot is freed on the same edge.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/ni_inject_fifo.sv
// Router injection stage: absorbs a no-backpressure flit stream, drops on full,
// tags head flits local/remote and keeps saturating accept/drop statistics.
module ni_inject_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int MY_CLUSTER = 0,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ni_inject_fifo_if.slave        nif,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic [CNT_W-1:0]       accept_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow
);
  localparam logic [CLUSTER_W-1:0] MY_CL = CLUSTER_W'(MY_CLUSTER);

  logic             empty, pop, push, drop;
  logic [FLIT_W-1:0] head;
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pop  = !empty && nif.out_ready;
  assign push = nif.in_valid && (!full || pop);
  assign drop = nif.in_valid && full && !pop;

  sync_fifo_fwft #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (nif.in_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (fifo_count)
  );

  assign nif.out_valid    = !empty;
  assign nif.out_data     = head;
  assign nif.out_is_local = !empty && (head[DEST_CLUSTER_LSB +: CLUSTER_W] == MY_CL);

  always_comb begin
    accept_cnt_d = accept_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    if (push) accept_cnt_d = sat_inc(accept_cnt_q);
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign accept_cnt = accept_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_ni_inject_fifo.sv
// Directed bench for ni_inject_fifo (DEPTH=8, MY_CLUSTER=0, CNT_W=16).
module tb_ni_inject_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fifo_count;
  logic        full;
  logic [15:0] accept_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  ni_inject_fifo_if nif ();

  ni_inject_fifo #(.DEPTH(8), .MY_CLUSTER(0), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .nif        (nif),
    .fifo_count (fifo_count),
    .full       (full),
    .accept_cnt (accept_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nif.in_valid  = 1'b0;
    nif.in_data   = '0;
    nif.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests_run++; if (nif.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", nif.out_valid); end
    tests_run++; if (nif.out_data !== 20'h0) begin tests_failed++; $display("FAIL reset_out_data got %05h want 00000", nif.out_data); end
    tests_run++; if (fifo_count !== 4'd0 || full !== 1'b0) begin tests_failed++; $display("FAIL reset_count_full got %0d/%0b want 0/0", fifo_count, full); end
    tests_run++; if (accept_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || nif.out_is_local !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stats got acc=%0d drop=%0d ovf=%0b loc=%0b want 0/0/0/0", accept_cnt, drop_cnt, overflow, nif.out_is_local); end
  endtask

  task automatic test_basic();
    logic [19:0] f [3];
    f = '{20'h00010, 20'h00021, 20'h00032};
    for (int i = 0; i < 3; i++) begin
      nif.in_valid = 1'b1; nif.in_data = f[i];
      tick();
    end
    nif.in_valid = 1'b0; nif.in_data = 'x;
    tests_run++; if (fifo_count !== 4'd3) begin tests_failed++; $display("FAIL basic_count got %0d want 3", fifo_count); end
    tests_run++; if (nif.out_data !== 20'h00010) begin tests_failed++; $display("FAIL basic_head got %05h want 00010", nif.out_data); end
    tests_run++; if (nif.out_is_local !== 1'b1) begin tests_failed++; $display("FAIL basic_local got %0b want 1", nif.out_is_local); end
    tests_run++; if (accept_cnt !== 16'd3 || drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL basic_stats got acc=%0d drop=%0d want 3/0", accept_cnt, drop_cnt); end
    nif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (nif.out_data !== f[i]) begin tests_failed++; $display("FAIL basic_drain%0d got %05h want %05h", i, nif.out_data, f[i]); end
      tick();
    end
    nif.out_ready = 1'b0;
    tests_run++; if (nif.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_empty got %0b want 0", nif.out_valid); end
  endtask

  task automatic test_local_tag();
    nif.in_valid = 1'b1; nif.in_data = 20'h0004C;
    tick();
    nif.in_valid = 1'b0; nif.in_data = 'x;
    tests_run++; if (nif.out_valid !== 1'b1 || nif.out_data !== 20'h0004C) begin tests_failed++; $display("FAIL tag_head got v=%0b d=%05h want 1/0004C", nif.out_valid, nif.out_data); end
    tests_run++; if (nif.out_is_local !== 1'b0) begin tests_failed++; $display("FAIL tag_remote got %0b want 0", nif.out_is_local); end
    nif.out_ready = 1'b1;
    tick();
    nif.out_ready = 1'b0;
    tests_run++; if (nif.out_valid !== 1'b0 || nif.out_data !== 20'h0 || nif.out_is_local !== 1'b0) begin
      tests_failed++; $display("FAIL tag_pop got v=%0b d=%05h l=%0b want 0/00000/0", nif.out_valid, nif.out_data, nif.out_is_local); end
    tests_run++; if (accept_cnt !== 16'd4) begin tests_failed++; $display("FAIL tag_accept got %0d want 4", accept_cnt); end
  endtask

  task automatic test_overflow();
    logic [19:0] exp;
    for (int i = 0; i < 10; i++) begin
      nif.in_valid = 1'b1; nif.in_data = {16'(16'h100 + i), 4'h5};
      tick();
      if (i == 7) begin
        tests_run++; if (full !== 1'b1 || fifo_count !== 4'd8) begin tests_failed++; $display("FAIL ovf_full8 got full=%0b cnt=%0d want 1/8", full, fifo_count); end
      end
    end
    nif.in_valid = 1'b0; nif.in_data = 'x;
    tests_run++; if (accept_cnt !== 16'd12 || drop_cnt !== 16'd2) begin tests_failed++; $display("FAIL ovf_stats got acc=%0d drop=%0d want 12/2", accept_cnt, drop_cnt); end
    tests_run++; if (overflow !== 1'b1 || full !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got ovf=%0b full=%0b want 1/1", overflow, full); end
    nif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = {16'(16'h100 + i), 4'h5};
      tests_run++; if (nif.out_data !== exp) begin tests_failed++; $display("FAIL ovf_drain%0d got %05h want %05h", i, nif.out_data, exp); end
      tick();
    end
    nif.out_ready = 1'b0;
    tests_run++; if (nif.out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_after got v=%0b cnt=%0d ovf=%0b want 0/0/1", nif.out_valid, fifo_count, overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [19:0] exp;
    for (int i = 0; i < 8; i++) begin
      nif.in_valid = 1'b1; nif.in_data = {16'(16'h200 + i), 4'h0};
      tick();
    end
    nif.in_valid = 1'b1; nif.in_data = 20'hABCD8; nif.out_ready = 1'b1;
    tick();
    nif.in_valid = 1'b0; nif.in_data = 'x; nif.out_ready = 1'b0;
    tests_run++; if (fifo_count !== 4'd8 || full !== 1'b1) begin tests_failed++; $display("FAIL pp_count got cnt=%0d full=%0b want 8/1", fifo_count, full); end
    tests_run++; if (drop_cnt !== 16'd2 || accept_cnt !== 16'd21) begin tests_failed++; $display("FAIL pp_stats got acc=%0d drop=%0d want 21/2", accept_cnt, drop_cnt); end
    nif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 20'hABCD8 : {16'(16'h201 + i), 4'h0};
      tests_run++; if (nif.out_data !== exp) begin tests_failed++; $display("FAIL pp_drain%0d got %05h want %05h", i, nif.out_data, exp); end
      tick();
    end
    nif.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] mq [$];
    logic [15:0] acc0, drp0;
    int m_acc = 0, m_drp = 0, rcv = 0, last_pl = 0;
    logic m_pop;
    acc0 = accept_cnt; drp0 = drop_cnt;
    for (int cyc = 0; cyc < 30; cyc++) begin
      nif.in_valid = 1'b1; nif.in_data = {16'(cyc + 1), 4'h0};
      nif.out_ready = (cyc % 2 == 0);
      tests_run++; if (nif.out_valid !== (mq.size() != 0)) begin tests_failed++; $display("FAIL b2b_valid%0d got %0b want %0b", cyc, nif.out_valid, mq.size() != 0); end
      m_pop = (mq.size() != 0) && nif.out_ready;
      if (m_pop) begin
        tests_run++; if (nif.out_data !== mq[0]) begin tests_failed++; $display("FAIL b2b_data%0d got %05h want %05h", cyc, nif.out_data, mq[0]); end
        tests_run++; if (int'(nif.out_data[19:4]) <= last_pl) begin tests_failed++; $display("FAIL b2b_order got %0d want >%0d", nif.out_data[19:4], last_pl); end
        last_pl = int'(nif.out_data[19:4]);
        void'(mq.pop_front()); rcv++;
      end
      if (mq.size() < 8 || m_pop) begin mq.push_back({16'(cyc + 1), 4'h0}); m_acc++; end
      else m_drp++;
      tick();
    end
    nif.in_valid = 1'b0; nif.in_data = 'x; nif.out_ready = 1'b1;
    for (int k = 0; k < 20 && nif.out_valid === 1'b1; k++) begin
      tests_run++; if (mq.size() == 0 || nif.out_data !== mq[0]) begin tests_failed++; $display("FAIL b2b_drain got %05h want %05h", nif.out_data, (mq.size() != 0) ? mq[0] : 20'h0); end
      if (mq.size() != 0) void'(mq.pop_front());
      rcv++;
      tick();
    end
    nif.out_ready = 1'b0;
    tests_run++; if (nif.out_valid !== 1'b0 || mq.size() != 0) begin tests_failed++; $display("FAIL b2b_drain_end got v=%0b left=%0d want 0/0", nif.out_valid, mq.size()); end
    tests_run++; if (int'(accept_cnt - acc0) != m_acc || int'(drop_cnt - drp0) != m_drp) begin
      tests_failed++; $display("FAIL b2b_stats got acc=%0d drop=%0d want %0d/%0d", accept_cnt - acc0, drop_cnt - drp0, m_acc, m_drp); end
    tests_run++; if (int'(accept_cnt - acc0) + int'(drop_cnt - drp0) != 30 || rcv != int'(accept_cnt - acc0)) begin
      tests_failed++; $display("FAIL b2b_total got acc+drop=%0d rcv=%0d want 30/%0d", (accept_cnt - acc0) + (drop_cnt - drp0), rcv, accept_cnt - acc0); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      nif.in_valid = 1'b1; nif.in_data = {16'(16'h300 + i), 4'h0};
      tick();
    end
    nif.in_valid = 1'b0; nif.in_data = 'x;
    tests_run++; if (fifo_count !== 4'd5) begin tests_failed++; $display("FAIL arst_pre got %0d want 5", fifo_count); end
    #3;
    rst = 1'b1;
    #1;
    tests_run++; if (nif.out_valid !== 1'b0 || nif.out_data !== 20'h0 || nif.out_is_local !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++; $display("FAIL arst_out got v=%0b d=%05h l=%0b cnt=%0d want 0/00000/0/0", nif.out_valid, nif.out_data, nif.out_is_local, fifo_count); end
    tests_run++; if (accept_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || full !== 1'b0) begin
      tests_failed++; $display("FAIL arst_stats got acc=%0d drop=%0d ovf=%0b full=%0b want 0/0/0/0", accept_cnt, drop_cnt, overflow, full); end
    tick();
    rst = 1'b0;
    nif.in_valid = 1'b1; nif.in_data = 20'h0ABC4;
    tick();
    nif.in_valid = 1'b0; nif.in_data = 'x;
    tests_run++; if (nif.out_valid !== 1'b1 || nif.out_data !== 20'h0ABC4 || nif.out_is_local !== 1'b0) begin
      tests_failed++; $display("FAIL arst_first got v=%0b d=%05h l=%0b want 1/0ABC4/0", nif.out_valid, nif.out_data, nif.out_is_local); end
    tests_run++; if (fifo_count !== 4'd1 || accept_cnt !== 16'd1) begin tests_failed++; $display("FAIL arst_count got cnt=%0d acc=%0d want 1/1", fifo_count, accept_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_local_tag();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
